rope_speed_scheduler: RTL and testbench
=======================================

// Module: rope_speed_scheduler
// PURPOSE
//  Shares one 7-bit random source among ROPES rope requesters that need a fresh enemy X speed.
//  - Arbitrates pending requests round-robin and sequences the source (trigger, wait, sample).
//  - Validates each sample against the granted rope's speed window; retries, then clamps.
//  - Delivers the speed and keeps a per-rope speed table. Sits between rope/enemy logic and the random gen.
// PARAMETERS
//  ROPES        6   number of ropes/requesters
//  LEFT_ROPES   3   ropes 0..LEFT_ROPES-1 are left ropes, rest are right ropes
//  SPEED_BITS   7   speed and random word width
//  RND_LATENCY  1   cycles from rnd_trigger to valid rnd_in (>=1)
//  MAX_RETRY    3   re-draws allowed after an out-of-window sample before clamping
//  BASE_MIN    45   window base minimum
//  BASE_MAX    70   window base maximum
//  STEP         7   per-rope window step
// PORTS
//  clk          in   1                  system clock
//  reset        in   1                  synchronous, active-high reset
//  enable       in   1                  1 = new grants allowed
//  req          in   ROPES              1-cycle pulse per rope: speed wanted
//  rnd_in       in   SPEED_BITS         random source output
//  rnd_trigger  out  1                  1-cycle draw strobe to random source
//  speed_valid  out  1                  1-cycle delivery strobe
//  speed_out    out  SPEED_BITS         delivered speed (valid with speed_valid)
//  speed_rope   out  $clog2(ROPES)      rope index of delivery
//  busy         out  1                  state != IDLE
//  rope_speed   out  ROPES x SPEED_BITS last delivered speed per rope
// BEHAVIOUR
//  Windows: left rope i  -> [BASE_MIN, BASE_MAX+STEP*i]
//           right rope i -> [BASE_MIN+STEP*(i-LEFT_ROPES), BASE_MAX]
//  Defaults give min = {45,45,45,45,52,59} and max = {70,77,84,70,70,70}.
//  Reset (synchronous, any state):
//   - state=IDLE; pending=0; rr_ptr=0; retry=0.
//   - rnd_trigger, speed_valid, speed_out and speed_rope are 0.
//   - rope_speed[i] = min(i).
//   - An in-flight draw is abandoned; no speed_valid is issued.
//  Pending: pending <= (pending | req) & ~served, where served is the one-hot of the rope in DELIVER.
//   - A req on a rope in the same cycle as its DELIVER re-queues it (set wins).
//   - Several reqs in one cycle are all queued.
//  FSM:
//   - IDLE: if enable && pending!=0, grant the first set bit at or after rr_ptr (wrapping).
//     Latch idx, retry=0, go to TRIG. If enable=0, pending keeps accumulating.
//   - TRIG: rnd_trigger=1 for one cycle; wait counter = RND_LATENCY; go to WAIT.
//   - WAIT: decrement the counter; when it reaches 0, register rnd_in into the sample; go to CHECK.
//   - CHECK:
//       in window          -> DELIVER with the sample;
//       else if retry<MAX_RETRY -> retry++, go to TRIG;
//       else               -> clamp (below min gives min, above max gives max), go to DELIVER.
//   - DELIVER: speed_valid=1; speed_out/speed_rope are driven; rope_speed[idx] is updated.
//     Clear pending[idx]; rr_ptr = (idx==ROPES-1) ? 0 : idx+1; go to IDLE.
//   - enable deasserting mid-draw does not abort; the draw completes.
//  Latency: req pulse in cycle 0, in-window first sample -> rnd_trigger in cycle 2, speed_valid in cycle RND_LATENCY+4.
//   - Each retry adds RND_LATENCY+2 cycles.
//   - Back-to-back grants: the next TRIG follows one IDLE cycle.
//  Arithmetic: window compares are unsigned on SPEED_BITS; window constants must fit SPEED_BITS.
//  Outputs are registered; speed_out and speed_rope hold their value until the next DELIVER.
// STRUCTURE
//  Package rope_speed_pkg holds:
//   - typedef enum state_t {IDLE, TRIG, WAIT, CHECK, DELIVER};
//   - SPEED_BITS and the window constants;
//   - functions rope_min(i) and rope_max(i).
//  Sub-module rope_rr_picker: combinational round-robin first-set finder.
//   - Inputs: pending, rr_ptr. Outputs: found, idx.
// TESTING (defaults unless stated)
//  1 Reset: pulse reset -> rope_speed={45,45,45,45,52,59}, all strobes 0, busy 0.
//  2 req[0] at cycle 0, rnd_in=60 -> rnd_trigger at cycle 2, speed_valid at cycle 5, speed_out=60, speed_rope=0.
//  3 req[5], rnd_in held 50 -> 4 rnd_trigger pulses, speed_out=59 (clamped), speed_valid at cycle 14.
//  4 req=6'b111111 in one cycle -> 6 deliveries, ropes 0..5 in order.
//    Then, with rr_ptr=2, req[0] and req[3] together -> rope 3 served before rope 0.
//  5 reset asserted in WAIT -> no speed_valid, pending=0, busy=0 next cycle, rope_speed back to minima.
//  6 req[2] in its own DELIVER cycle -> a second delivery for rope 2 follows.
//    enable=0 with req pending -> no rnd_trigger until enable=1.

Source files
------------

// File: rtl/rope_speed_pkg.sv
// Shared types, widths and speed-window constants for the rope speed scheduler.
// Pure declarations and helpers; no timing of its own.
// No flow control here; window helpers are pure functions of rope index.
package rope_speed_pkg;

    localparam int ROPES_DEF       = 6;
    localparam int LEFT_ROPES_DEF  = 3;
    localparam int RND_LATENCY_DEF = 1;
    localparam int MAX_RETRY_DEF   = 3;

    localparam int SPEED_BITS = 7;
    localparam int BASE_MIN   = 45;
    localparam int BASE_MAX   = 70;
    localparam int STEP       = 7;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT,
        CHECK,
        DELIVER
    } state_t;

    // Left ropes share the base minimum; right ropes raise it one step per rope.
    function automatic logic [SPEED_BITS-1:0] rope_min(input int i, input int left_ropes);
        int v;
        v = (i < left_ropes) ? BASE_MIN : BASE_MIN + STEP * (i - left_ropes);
        return v[SPEED_BITS-1:0];
    endfunction

    // Left ropes widen the maximum one step per rope; right ropes share the base maximum.
    function automatic logic [SPEED_BITS-1:0] rope_max(input int i, input int left_ropes);
        int v;
        v = (i < left_ropes) ? BASE_MAX + STEP * i : BASE_MAX;
        return v[SPEED_BITS-1:0];
    endfunction

endpackage

// File: rtl/rope_speed_scheduler_picker.sv
// Round-robin first-set finder over the pending rope mask.
// Purely combinational, zero latency.
// No backpressure; found=0 when nothing is pending.
module rope_rr_picker #(
    parameter int ROPES = 6,
    parameter int IW    = 3
) (
    input  logic [ROPES-1:0] pending,
    input  logic [IW-1:0]    rr_ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);

    logic          hit_hi;
    logic [IW-1:0] idx_hi;
    logic          hit_lo;
    logic [IW-1:0] idx_lo;

    // Lowest set bit at or after the pointer wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        hit_hi = 1'b0;
        idx_hi = '0;
        hit_lo = 1'b0;
        idx_lo = '0;
        // Descending scan so the lowest qualifying index is the last one written.
        for (int i = ROPES - 1; i >= 0; i--) begin
            if (pending[i] && (IW'(i) >= rr_ptr)) begin
                hit_hi = 1'b1;
                idx_hi = IW'(i);
            end
            if (pending[i]) begin
                hit_lo = 1'b1;
                idx_lo = IW'(i);
            end
        end
        found = hit_hi | hit_lo;
        idx   = hit_hi ? idx_hi : idx_lo;
    end

endmodule

// File: rtl/rope_speed_scheduler.sv
// Shares one random source among rope requesters: round-robin grant, draw, window check, deliver.
// req pulse -> rnd_trigger 2 cycles later -> speed_valid RND_LATENCY+4 cycles after req; +RND_LATENCY+2 per retry.
// No backpressure on outputs; requests are held in a pending mask, new grants gated by enable.
module rope_speed_scheduler
    import rope_speed_pkg::*;
#(
    parameter int  ROPES       = ROPES_DEF,
    parameter int  LEFT_ROPES  = LEFT_ROPES_DEF,
    parameter int  RND_LATENCY = RND_LATENCY_DEF,
    parameter int  MAX_RETRY   = MAX_RETRY_DEF,
    localparam int IW          = (ROPES > 1) ? $clog2(ROPES) : 1,
    localparam int CW          = $clog2(RND_LATENCY + 2),
    localparam int RW          = $clog2(MAX_RETRY + 2)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [ROPES-1:0]            req,
    input  logic [SPEED_BITS-1:0]       rnd_in,
    output logic                        rnd_trigger,
    output logic                        speed_valid,
    output logic [SPEED_BITS-1:0]       speed_out,
    output logic [IW-1:0]               speed_rope,
    output logic                        busy,
    output logic [ROPES*SPEED_BITS-1:0] rope_speed
);

    state_t                             state_q;
    logic [ROPES-1:0]                   pending_q;
    logic [ROPES-1:0]                   pending_d;
    logic [ROPES-1:0]                   served;
    logic [IW-1:0]                      rr_ptr_q;
    logic [IW-1:0]                      idx_q;
    logic [RW-1:0]                      retry_q;
    logic [CW-1:0]                      wait_q;
    logic [SPEED_BITS-1:0]              sample_q;
    logic                               rnd_trigger_q;
    logic                               speed_valid_q;
    logic [SPEED_BITS-1:0]              speed_out_q;
    logic [IW-1:0]                      speed_rope_q;
    logic [ROPES-1:0][SPEED_BITS-1:0]   rope_speed_q;

    logic                               pick_found;
    logic [IW-1:0]                      pick_idx;
    logic [SPEED_BITS-1:0]              win_min;
    logic [SPEED_BITS-1:0]              win_max;
    logic                               in_win;
    logic [SPEED_BITS-1:0]              deliver_speed;

    rope_rr_picker #(
        .ROPES (ROPES),
        .IW    (IW)
    ) u_picker (
        .pending (pending_q),
        .rr_ptr  (rr_ptr_q),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // Pending update: the rope being delivered is cleared, but a fresh req in that cycle re-queues it.
    always_comb begin
        served = '0;
        for (int i = 0; i < ROPES; i++) begin
            if ((state_q == DELIVER) && (idx_q == IW'(i))) begin
                served[i] = 1'b1;
            end
        end
        pending_d = (pending_q & ~served) | req;
    end

    // Window of the granted rope and the speed to deliver (sample if inside, nearest bound otherwise).
    always_comb begin
        win_min = rope_min(int'(idx_q), LEFT_ROPES);
        win_max = rope_max(int'(idx_q), LEFT_ROPES);
        in_win  = (sample_q >= win_min) && (sample_q <= win_max);
        if (in_win) begin
            deliver_speed = sample_q;
        end else if (sample_q < win_min) begin
            deliver_speed = win_min;
        end else begin
            deliver_speed = win_max;
        end
    end

    // Pending request mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Grant/draw/check/deliver sequencer with registered strobes and speed table.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            idx_q         <= '0;
            retry_q       <= '0;
            wait_q        <= '0;
            sample_q      <= '0;
            rnd_trigger_q <= 1'b0;
            speed_valid_q <= 1'b0;
            speed_out_q   <= '0;
            speed_rope_q  <= '0;
            for (int i = 0; i < ROPES; i++) begin
                rope_speed_q[i] <= rope_min(i, LEFT_ROPES);
            end
        end else begin
            rnd_trigger_q <= 1'b0;
            speed_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable && pick_found) begin
                        idx_q         <= pick_idx;
                        retry_q       <= '0;
                        rnd_trigger_q <= 1'b1;
                        state_q       <= TRIG;
                    end
                end
                TRIG: begin
                    wait_q  <= CW'(RND_LATENCY);
                    state_q <= WAIT;
                end
                WAIT: begin
                    wait_q <= wait_q - 1'b1;
                    // Counter about to hit zero: the source output is valid this cycle.
                    if (wait_q == CW'(1)) begin
                        sample_q <= rnd_in;
                        state_q  <= CHECK;
                    end
                end
                CHECK: begin
                    if (in_win || (retry_q == RW'(MAX_RETRY))) begin
                        speed_valid_q <= 1'b1;
                        speed_out_q   <= deliver_speed;
                        speed_rope_q  <= idx_q;
                        for (int i = 0; i < ROPES; i++) begin
                            if (idx_q == IW'(i)) begin
                                rope_speed_q[i] <= deliver_speed;
                            end
                        end
                        state_q <= DELIVER;
                    end else begin
                        retry_q       <= retry_q + 1'b1;
                        rnd_trigger_q <= 1'b1;
                        state_q       <= TRIG;
                    end
                end
                DELIVER: begin
                    rr_ptr_q <= (idx_q == IW'(ROPES - 1)) ? '0 : idx_q + 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rnd_trigger = rnd_trigger_q;
    assign speed_valid = speed_valid_q;
    assign speed_out   = speed_out_q;
    assign speed_rope  = speed_rope_q;
    assign busy        = (state_q != IDLE);
    assign rope_speed  = rope_speed_q;

endmodule

// File: tb/tb_rope_speed_scheduler.sv
module tb_rope_speed_scheduler;

    localparam int ROPES     = 6;
    localparam int SB        = 7;
    localparam int MAX_RETRY = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [ROPES-1:0] req;
    logic [SB-1:0]    rnd_in;
    wire              rnd_trigger;
    wire              speed_valid;
    wire  [SB-1:0]    speed_out;
    wire  [2:0]       speed_rope;
    wire              busy;
    wire  [ROPES*SB-1:0] rope_speed;

    rope_speed_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req         (req),
        .rnd_in      (rnd_in),
        .rnd_trigger (rnd_trigger),
        .speed_valid (speed_valid),
        .speed_out   (speed_out),
        .speed_rope  (speed_rope),
        .busy        (busy),
        .rope_speed  (rope_speed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    // Observation logs
    int fixed_rnd = -1;
    int draws_since = 0;
    int all_draws[$];
    int trig_cyc[$];
    int dlv_rope[$];
    int dlv_speed[$];
    int dlv_cyc[$];
    int dlv_nd[$];

    // Reference model state: pending set and round-robin pointer
    bit mdl_pend[ROPES];
    int mdl_rr = 0;

    function automatic int wmin(input int r);
        return (r < 3) ? 45 : 45 + 7 * (r - 3);
    endfunction

    function automatic int wmax(input int r);
        return (r < 3) ? 70 + 7 * r : 70;
    endfunction

    // Random source emulation and output monitor
    always @(negedge clk) begin
        if (reset) begin
            draws_since = 0;
            all_draws.delete();
        end else begin
            if (rnd_trigger === 1'b1) begin
                int v;
                v = (fixed_rnd >= 0) ? fixed_rnd : int'($urandom_range(30, 95));
                rnd_in = SB'(v);
                all_draws.push_back(v);
                trig_cyc.push_back(cyc);
                draws_since++;
            end
            if (speed_valid === 1'b1) begin
                dlv_rope.push_back(int'(speed_rope));
                dlv_speed.push_back(int'(speed_out));
                dlv_cyc.push_back(cyc);
                dlv_nd.push_back(draws_since);
                draws_since = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        trig_cyc.delete();
        dlv_rope.delete();
        dlv_speed.delete();
        dlv_cyc.delete();
        dlv_nd.delete();
    endtask

    task automatic model_reset();
        for (int i = 0; i < ROPES; i++) mdl_pend[i] = 1'b0;
        mdl_rr = 0;
    endtask

    task automatic model_req(input int mask);
        for (int i = 0; i < ROPES; i++) if (mask[i]) mdl_pend[i] = 1'b1;
    endtask

    // Next grant by round-robin, then the speed rule applied to that grant's draws.
    task automatic model_delivery(input int n_act, output int er, output int es, output int en);
        int v;
        er = -1; es = -1; en = 0;
        for (int k = 0; k < ROPES; k++) begin
            int j;
            j = (mdl_rr + k) % ROPES;
            if (er < 0 && mdl_pend[j]) er = j;
        end
        if (er >= 0) begin
            mdl_pend[er] = 1'b0;
            mdl_rr = (er + 1) % ROPES;
        end
        for (int k = 0; k < n_act; k++) begin
            v = (all_draws.size() > 0) ? all_draws.pop_front() : -1;
            if (es < 0 && er >= 0) begin
                en++;
                if (v >= wmin(er) && v <= wmax(er)) es = v;
                else if (en == MAX_RETRY + 1) es = (v < wmin(er)) ? wmin(er) : wmax(er);
            end
        end
    endtask

    task automatic wait_dlv(input int n, output bit ok);
        int t;
        t = 0;
        while (dlv_rope.size() < n && t < 400) begin
            tick(1);
            t++;
        end
        ok = (dlv_rope.size() >= n);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; req = '0; rnd_in = '0;
        tick(2);
        for (int i = 0; i < ROPES; i++) begin
            checks++;
            if (int'(rope_speed[i*SB +: SB]) !== wmin(i))
                $display("FAIL reset_rope_speed[%0d]: got %0d expected %0d", i, rope_speed[i*SB +: SB], wmin(i));
            else passed++;
        end
        checks++;
        if ({rnd_trigger, speed_valid, busy} !== 3'b000)
            $display("FAIL reset_strobes: got trig/valid/busy=%b expected 000", {rnd_trigger, speed_valid, busy});
        else passed++;
        checks++;
        if ({speed_out, speed_rope} !== 10'd0)
            $display("FAIL reset_speed_out_rope: got %0d/%0d expected 0/0", speed_out, speed_rope);
        else passed++;
        reset = 1'b0;
        model_reset();
        tick(1);
    endtask

    task automatic test_single_latency();
        int c0, er, es, en;
        bit ok;
        clear_logs();
        fixed_rnd = 60;
        c0 = cyc;
        req = 6'b000001; model_req(1);
        tick(1);
        req = '0;
        wait_dlv(1, ok);
        checks++;
        if (!ok) $display("FAIL single_timeout: got %0d deliveries expected 1", dlv_rope.size());
        else passed++;
        if (ok) begin
            model_delivery(dlv_nd[0], er, es, en);
            checks++;
            if (trig_cyc.size() < 1 || trig_cyc[0] !== c0 + 2)
                $display("FAIL single_trig_cycle: got %0d expected %0d", (trig_cyc.size() > 0) ? trig_cyc[0] - c0 : -1, 2);
            else passed++;
            checks++;
            if (dlv_cyc[0] !== c0 + 5) $display("FAIL single_valid_cycle: got %0d expected 5", dlv_cyc[0] - c0);
            else passed++;
            checks++;
            if (dlv_speed[0] !== 60 || es !== 60) $display("FAIL single_speed: got %0d expected 60", dlv_speed[0]);
            else passed++;
            checks++;
            if (dlv_rope[0] !== 0 || er !== 0) $display("FAIL single_rope: got %0d expected 0", dlv_rope[0]);
            else passed++;
            checks++;
            if (int'(rope_speed[0 +: SB]) !== 60) $display("FAIL single_table: got %0d expected 60", rope_speed[0 +: SB]);
            else passed++;
        end
        tick(3);
    endtask

    task automatic test_clamp();
        int c0, er, es, en;
        bit ok;
        clear_logs();
        fixed_rnd = 50;
        c0 = cyc;
        req = 6'b100000; model_req(32);
        tick(1);
        req = '0;
        wait_dlv(1, ok);
        checks++;
        if (!ok) $display("FAIL clamp_timeout: got %0d deliveries expected 1", dlv_rope.size());
        else passed++;
        if (ok) begin
            model_delivery(dlv_nd[0], er, es, en);
            checks++;
            if (trig_cyc.size() !== 4 || en !== 4) $display("FAIL clamp_trig_count: got %0d expected 4", trig_cyc.size());
            else passed++;
            checks++;
            if (trig_cyc.size() < 4 || trig_cyc[3] !== c0 + 11)
                $display("FAIL clamp_last_trig: got %0d expected 11", (trig_cyc.size() >= 4) ? trig_cyc[3] - c0 : -1);
            else passed++;
            checks++;
            if (dlv_cyc[0] !== c0 + 14) $display("FAIL clamp_valid_cycle: got %0d expected 14", dlv_cyc[0] - c0);
            else passed++;
            checks++;
            if (dlv_speed[0] !== 59 || es !== 59) $display("FAIL clamp_speed: got %0d expected 59", dlv_speed[0]);
            else passed++;
            checks++;
            if (dlv_rope[0] !== 5) $display("FAIL clamp_rope: got %0d expected 5", dlv_rope[0]);
            else passed++;
        end
        tick(3);
    endtask

    task automatic test_round_robin();
        int er, es, en, tix;
        bit ok;
        clear_logs();
        fixed_rnd = -1;
        req = 6'b111111; model_req(63);
        tick(1);
        req = '0;
        wait_dlv(6, ok);
        checks++;
        if (!ok) $display("FAIL rr_burst_timeout: got %0d deliveries expected 6", dlv_rope.size());
        else passed++;
        tix = 0;
        for (int k = 0; k < dlv_rope.size() && k < 6; k++) begin
            model_delivery(dlv_nd[k], er, es, en);
            checks++;
            if (dlv_rope[k] !== k || er !== k) $display("FAIL rr_burst_rope[%0d]: got %0d expected %0d", k, dlv_rope[k], k);
            else passed++;
            checks++;
            if (dlv_speed[k] !== es) $display("FAIL rr_burst_speed[%0d]: got %0d expected %0d", k, dlv_speed[k], es);
            else passed++;
            checks++;
            if (dlv_nd[k] !== en) $display("FAIL rr_burst_draws[%0d]: got %0d expected %0d", k, dlv_nd[k], en);
            else passed++;
            tix += dlv_nd[k];
            if (k < 5) begin
                checks++;
                if (tix >= trig_cyc.size() || trig_cyc[tix] !== dlv_cyc[k] + 2)
                    $display("FAIL back_to_back[%0d]: got %0d expected %0d", k, (tix < trig_cyc.size()) ? trig_cyc[tix] : -1, dlv_cyc[k] + 2);
                else passed++;
            end
        end
        tick(3);
        // Serve rope 1 so the pointer sits at 2, then ropes 0 and 3 together.
        clear_logs();
        req = 6'b000010; model_req(2);
        tick(1);
        req = '0;
        wait_dlv(1, ok);
        tick(3);
        if (ok) model_delivery(dlv_nd[0], er, es, en);
        clear_logs();
        req = 6'b001001; model_req(9);
        tick(1);
        req = '0;
        wait_dlv(2, ok);
        checks++;
        if (!ok) $display("FAIL rr_wrap_timeout: got %0d deliveries expected 2", dlv_rope.size());
        else passed++;
        if (ok) begin
            model_delivery(dlv_nd[0], er, es, en);
            checks++;
            if (dlv_rope[0] !== 3 || er !== 3) $display("FAIL rr_wrap_first: got %0d expected 3", dlv_rope[0]);
            else passed++;
            model_delivery(dlv_nd[1], er, es, en);
            checks++;
            if (dlv_rope[1] !== 0 || er !== 0) $display("FAIL rr_wrap_second: got %0d expected 0", dlv_rope[1]);
            else passed++;
            checks++;
            if (dlv_speed[1] !== es) $display("FAIL rr_wrap_speed: got %0d expected %0d", dlv_speed[1], es);
            else passed++;
        end
        tick(3);
    endtask

    task automatic test_reset_midflight();
        int t;
        clear_logs();
        fixed_rnd = 60;
        req = 6'b000100;
        tick(1);
        req = '0;
        t = 0;
        while (trig_cyc.size() < 1 && t < 50) begin tick(1); t++; end
        checks++;
        if (trig_cyc.size() < 1) $display("FAIL midreset_no_trigger: got 0 triggers expected 1");
        else passed++;
        // Now in the wait cycle after the trigger.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        model_reset();
        checks++;
        if ({busy, speed_valid} !== 2'b00) $display("FAIL midreset_busy_valid: got %b expected 00", {busy, speed_valid});
        else passed++;
        for (int i = 0; i < ROPES; i++) begin
            checks++;
            if (int'(rope_speed[i*SB +: SB]) !== wmin(i))
                $display("FAIL midreset_table[%0d]: got %0d expected %0d", i, rope_speed[i*SB +: SB], wmin(i));
            else passed++;
        end
        tick(10);
        checks++;
        if (dlv_rope.size() !== 0) $display("FAIL midreset_delivery: got %0d deliveries expected 0", dlv_rope.size());
        else passed++;
        checks++;
        if (trig_cyc.size() !== 1) $display("FAIL midreset_pending: got %0d triggers expected 1", trig_cyc.size());
        else passed++;
    endtask

    task automatic test_requeue();
        int c0, er, es, en;
        bit ok;
        clear_logs();
        fixed_rnd = 60;
        c0 = cyc;
        req = 6'b000100;
        tick(1);
        req = '0;
        tick(4);
        req = 6'b000100;
        tick(1);
        req = '0;
        wait_dlv(2, ok);
        checks++;
        if (!ok) $display("FAIL requeue_timeout: got %0d deliveries expected 2", dlv_rope.size());
        else passed++;
        if (ok) begin
            model_req(4); model_delivery(dlv_nd[0], er, es, en);
            model_req(4); model_delivery(dlv_nd[1], er, es, en);
            checks++;
            if (dlv_cyc[0] !== c0 + 5) $display("FAIL requeue_first_cycle: got %0d expected 5", dlv_cyc[0] - c0);
            else passed++;
            checks++;
            if (dlv_rope[1] !== 2 || er !== 2) $display("FAIL requeue_rope: got %0d expected 2", dlv_rope[1]);
            else passed++;
            checks++;
            if (dlv_cyc[1] !== c0 + 10) $display("FAIL requeue_second_cycle: got %0d expected 10", dlv_cyc[1] - c0);
            else passed++;
        end
        tick(3);
    endtask

    task automatic test_enable();
        int ce, er, es, en, t;
        bit ok;
        clear_logs();
        fixed_rnd = -1;
        enable = 1'b0;
        req = 6'b010000; model_req(16);
        tick(1);
        req = '0;
        tick(12);
        checks++;
        if (trig_cyc.size() !== 0 || busy !== 1'b0)
            $display("FAIL enable_hold: got %0d triggers busy=%b expected 0 triggers busy=0", trig_cyc.size(), busy);
        else passed++;
        ce = cyc;
        enable = 1'b1;
        t = 0;
        while (trig_cyc.size() < 1 && t < 50) begin tick(1); t++; end
        // Dropping enable mid-draw must not abort the draw.
        enable = 1'b0;
        checks++;
        if (trig_cyc.size() < 1 || trig_cyc[0] !== ce + 1)
            $display("FAIL enable_trig_cycle: got %0d expected 1", (trig_cyc.size() > 0) ? trig_cyc[0] - ce : -1);
        else passed++;
        wait_dlv(1, ok);
        enable = 1'b1;
        checks++;
        if (!ok) $display("FAIL enable_timeout: got %0d deliveries expected 1", dlv_rope.size());
        else passed++;
        if (ok) begin
            model_delivery(dlv_nd[0], er, es, en);
            checks++;
            if (dlv_rope[0] !== 4 || er !== 4) $display("FAIL enable_rope: got %0d expected 4", dlv_rope[0]);
            else passed++;
            checks++;
            if (dlv_speed[0] !== es) $display("FAIL enable_speed: got %0d expected %0d", dlv_speed[0], es);
            else passed++;
            checks++;
            if (int'(rope_speed[4*SB +: SB]) !== es) $display("FAIL enable_table: got %0d expected %0d", rope_speed[4*SB +: SB], es);
            else passed++;
        end
        tick(3);
    endtask

    task automatic test_random();
        int mask, n, er, es, en;
        bit ok;
        fixed_rnd = -1;
        for (int r = 0; r < 10; r++) begin
            clear_logs();
            mask = int'($urandom_range(1, 63));
            n = $countones(mask);
            req = ROPES'(mask); model_req(mask);
            tick(1);
            req = '0;
            wait_dlv(n, ok);
            checks++;
            if (!ok) $display("FAIL random_timeout[%0d]: got %0d deliveries expected %0d", r, dlv_rope.size(), n);
            else passed++;
            for (int k = 0; k < dlv_rope.size() && k < n; k++) begin
                model_delivery(dlv_nd[k], er, es, en);
                checks++;
                if (dlv_rope[k] !== er || dlv_speed[k] !== es || dlv_nd[k] !== en)
                    $display("FAIL random[%0d.%0d]: got rope %0d speed %0d draws %0d expected rope %0d speed %0d draws %0d",
                             r, k, dlv_rope[k], dlv_speed[k], dlv_nd[k], er, es, en);
                else passed++;
                checks++;
                if (er >= 0 && int'(rope_speed[er*SB +: SB]) !== es && k == n - 1)
                    $display("FAIL random_table[%0d]: got %0d expected %0d", r, rope_speed[er*SB +: SB], es);
                else passed++;
            end
            tick(3);
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        req = '0;
        rnd_in = '0;
        test_reset();
        test_single_latency();
        test_clamp();
        test_round_robin();
        test_reset_midflight();
        test_requeue();
        test_enable();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
